// File: rtl/apb_master_seq.sv
// APB requester: queues write/read commands and runs each one as an APB SETUP/ACCESS transfer.
// Optional ACCESS wait-state timeout is built only when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_seq #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state, state_d;

  logic                  fifo_write [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr  [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata [CMD_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  fifo_full, fifo_empty, push, pop;

  logic                  psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic                  complete, abort, timeout_hit;

  assign fifo_full  = (count == CNT_W'(CMD_DEPTH));
  assign fifo_empty = (count == '0);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign busy       = (state != IDLE) || !fifo_empty;

  always_ff @(posedge PCLK) begin
    if (push) begin
      fifo_write[wr_ptr] <= cmd_write;
      fifo_addr[wr_ptr]  <= cmd_addr;
      fifo_wdata[wr_ptr] <= cmd_wdata;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d   = state;
    psel_d    = 1'b0;
    penable_d = 1'b0;
    pwrite_d  = PWRITE;
    paddr_d   = PADDR;
    pwdata_d  = PWDATA;
    pop       = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        pwdata_d = '0;
        // A new transfer may start only if its response will have somewhere to land.
        if (!fifo_empty && (!rsp_valid || rsp_ready)) begin
          state_d  = SETUP;
          pop      = 1'b1;
          psel_d   = 1'b1;
          pwrite_d = fifo_write[rd_ptr];
          paddr_d  = fifo_addr[rd_ptr];
          pwdata_d = fifo_write[rd_ptr] ? fifo_wdata[rd_ptr] : '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d  = IDLE;
          complete = 1'b1;
          pwdata_d = '0;
        end else if (timeout_hit) begin
          state_d  = IDLE;
          abort    = 1'b1;
          pwdata_d = '0;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '1;
      PWDATA  <= '0;
    end else begin
      PSEL    <= psel_d;
      PENABLE <= penable_d;
      PWRITE  <= pwrite_d;
      PADDR   <= paddr_d;
      PWDATA  <= pwdata_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] wait_cnt;
  logic          rsp_to_q;

  // The abort fires on the TIMEOUT_CYC-th ACCESS cycle seen with PREADY low.
  assign timeout_hit = (wait_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
    end else if (state == IDLE && state_d == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !PREADY && !timeout_hit) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)      rsp_to_q <= 1'b0;
    else if (complete) rsp_to_q <= 1'b0;
    else if (abort)    rsp_to_q <= 1'b1;
  end

  assign rsp_timeout = rsp_to_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // A completion in the same cycle as a handshake reloads the slot instead of clearing it.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (complete) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= PWRITE ? '0 : PRDATA;
      rsp_err   <= PSLVERR;
    end else if (abort) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_master_seq.sv
// Directed bench for apb_master_seq with a behavioural APB slave and a response scoreboard.
// Test 5 follows APB_MASTER_TIMEOUT_EN the same way the design does.
module tb_apb_master_seq;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
  logic [7:0] rsp_rdata;
  logic       PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [7:0] PADDR, PWDATA, PRDATA;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  slave_mem [256];
  logic [7:0]  ref_mem   [256];
  logic [9:0]  sb [$];
  int unsigned wait_cfg = 0;
  int unsigned wcnt = 0;
  logic        stall = 1'b0;
  logic        err_en = 1'b0;

  apb_master_seq #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .CMD_DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  // Behavioural slave: wait_cfg wait states, stall holds PREADY low, errors on address FF.
  assign PREADY  = PSEL && PENABLE && !stall && (wcnt >= wait_cfg);
  assign PSLVERR = err_en && PSEL && PENABLE && (PADDR == 8'hFF);
  assign PRDATA  = slave_mem[PADDR];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PREADY) begin
      wcnt <= 0;
      if (PWRITE && !PSLVERR) slave_mem[PADDR] <= PWDATA;
    end else if (PSEL && PENABLE) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: compares every response at the cycle it is handshaken.
  always @(negedge PCLK) begin
    if (PRESETn === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      checkOutput("rsp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) checkOutput("rsp_fields", {rsp_rdata, rsp_err, rsp_timeout}, sb.pop_front());
    end
  end

  // Queues the expected response, then offers the command until accepted.
  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                               input logic exp_to);
    logic err, ok, accepted;
    err = err_en && (addr == 8'hFF);
    if (exp_to)  sb.push_back({8'h00, 1'b1, 1'b1});
    else if (wr) begin
      sb.push_back({8'h00, err, 1'b0});
      if (!err) ref_mem[addr] = wdata;
    end else     sb.push_back({ref_mem[addr], err, 1'b0});
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    accepted  = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge PCLK);
      ok = cmd_ready;
      @(posedge PCLK);
      #1;
      accepted = ok;
    end
    cmd_valid = 1'b0;
    checkOutput("cmd_accepted", 32'(accepted), 32'd1);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300; i++) begin
      @(posedge PCLK);
      #1;
      if (!busy && !rsp_valid) break;
    end
    checkOutput("drain_busy_valid", {busy, rsp_valid}, 32'd0);
    checkOutput("drain_sb_empty", sb.size(), 32'd0);
  endtask

  task automatic cycle();
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    int en_cycles;
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 8'(i * 3 + 7);
      ref_mem[i]   = 8'(i * 3 + 7);
    end
    slave_mem[2] = 8'h3C;
    ref_mem[2]   = 8'h3C;
    PRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (3) cycle();
    checkOutput("rst_psel_penable_pwrite", {PSEL, PENABLE, PWRITE}, 32'd0);
    checkOutput("rst_paddr", PADDR, 32'hFF);
    checkOutput("rst_pwdata", PWDATA, 32'h00);
    checkOutput("rst_cmd_ready", cmd_ready, 32'd1);
    checkOutput("rst_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 32'd0);
    checkOutput("rst_busy", busy, 32'd0);
    PRESETn = 1'b1;
    cycle();

    // Test 1: zero-wait write, cycle-exact latency
    applyStimulus(1'b1, 8'h00, 8'hA5, 1'b0);
    checkOutput("t1_T0_psel", PSEL, 32'd0);
    cycle();
    checkOutput("t1_T1_psel_penable", {PSEL, PENABLE}, 32'b10);
    checkOutput("t1_T1_pwrite", PWRITE, 32'd1);
    checkOutput("t1_T1_paddr", PADDR, 32'h00);
    checkOutput("t1_T1_pwdata", PWDATA, 32'hA5);
    cycle();
    checkOutput("t1_T2_psel_penable", {PSEL, PENABLE}, 32'b11);
    checkOutput("t1_T2_pwdata", PWDATA, 32'hA5);
    cycle();
    checkOutput("t1_T3_psel_penable", {PSEL, PENABLE}, 32'b00);
    checkOutput("t1_T3_rsp_valid", rsp_valid, 32'd1);
    waitDrain();

    // Test 2: read with two wait states
    wait_cfg = 2;
    applyStimulus(1'b0, 8'h02, 8'h00, 1'b0);
    en_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (PENABLE) begin
        en_cycles++;
        checkOutput("t2_paddr_stable", PADDR, 32'h02);
        checkOutput("t2_pwdata_read", PWDATA, 32'h00);
      end
    end
    checkOutput("t2_penable_cycles", en_cycles, 32'd3);
    waitDrain();
    wait_cfg = 0;

    // Test 3: blocked response slot, FIFO fills, then drains in order
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'(8'h10 + i), 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      checkOutput("t3_no_setup", PSEL, 32'd0);
    end
    checkOutput("t3_cmd_ready_full", cmd_ready, 32'd0);
    checkOutput("t3_rsp_held", rsp_valid, 32'd1);
    checkOutput("t3_busy", busy, 32'd1);
    rsp_ready = 1'b1;
    applyStimulus(1'b0, 8'h15, 8'h00, 1'b0);
    waitDrain();

    // Test 4: slave error on write, next read clean
    err_en = 1'b1;
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b0);
    applyStimulus(1'b0, 8'h03, 8'h00, 1'b0);
    waitDrain();
    err_en = 1'b0;

    // Test 5: PREADY held low
    stall = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
    applyStimulus(1'b0, 8'h20, 8'h00, 1'b1);
    en_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (PENABLE) en_cycles++;
    end
    checkOutput("t5_timeout_cycles", en_cycles, 32'd16);
    waitDrain();
    applyStimulus(1'b0, 8'h20, 8'h00, 1'b0);
    repeat (2) cycle();
`else
    applyStimulus(1'b0, 8'h20, 8'h00, 1'b0);
    repeat (100) cycle();
    checkOutput("t5_still_waiting", {PSEL, PENABLE}, 32'b11);
    checkOutput("t5_no_timeout", {rsp_valid, rsp_timeout}, 32'd0);
`endif

    // Test 6: reset during ACCESS with two commands queued
    applyStimulus(1'b0, 8'h21, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h22, 8'h00, 1'b0);
    cycle();
    checkOutput("t6_in_access", {PSEL, PENABLE}, 32'b11);
    PRESETn = 1'b0;
    #1;
    checkOutput("t6_psel_penable", {PSEL, PENABLE}, 32'd0);
    checkOutput("t6_paddr", PADDR, 32'hFF);
    checkOutput("t6_cmd_ready", cmd_ready, 32'd1);
    checkOutput("t6_rsp_valid", rsp_valid, 32'd0);
    checkOutput("t6_busy", busy, 32'd0);
    sb.delete();
    stall = 1'b0;
    cycle();
    PRESETn = 1'b1;
    cycle();

    // Recovery after reset: write then read back
    applyStimulus(1'b1, 8'h30, 8'h5A, 1'b0);
    applyStimulus(1'b0, 8'h30, 8'h00, 1'b0);
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
